// File: rtl/enc4_2_rr_pkg.sv
// Shared types and default sizing for the registered request encoder.
package enc_pkg;
  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE,
    HOLD
  } enc_state_t;
endpackage

// File: rtl/enc4_2_rr_if.sv
// Request/result handshake bundle for enc4_2_rr.
interface enc4_2_rr_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) ();
  localparam int W = $clog2(N);

  logic [N-1:0]     req;
  logic             en;
  logic [W-1:0]     code;
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] gnt_cnt;

  modport master (
    output req,
    output en,
    output ready,
    input  code,
    input  valid,
    input  gnt_cnt
  );

  modport slave (
    input  req,
    input  en,
    input  ready,
    output code,
    output valid,
    output gnt_cnt
  );
endinterface

// File: rtl/enc4_2_rr_pri_enc.sv
// Lowest-set-bit priority encoder: index of the lowest high request line.
module pri_enc_n #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/enc4_2_rr.sv
// Registered N-to-log2(N) request encoder with valid/ready hold.
// ENC_RR_FAIR_EN selects round-robin; otherwise fixed lowest-index priority.
module enc4_2_rr
  import enc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic       clk,
  input logic       reset,
  enc4_2_rr_if.slave bus
);
  localparam int W = $clog2(N);

  enc_state_t       r_state;
  enc_state_t       w_state_nxt;
  logic [W-1:0]     r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     w_win;
  logic [W-1:0]     w_idx_all;
  logic             w_any_all;
  logic             w_accept;
  logic             w_capture;

  pri_enc_n #(.N(N), .W(W)) u_all (
    .i_req (bus.req),
    .o_idx (w_idx_all),
    .o_any (w_any_all)
  );

  assign w_accept  = (r_state == HOLD) && bus.ready;
  assign w_capture = ((r_state == IDLE) || w_accept)
                     && bus.en && w_any_all;

`ifdef ENC_RR_FAIR_EN
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr;
  logic [N-1:0] w_mask;
  logic [W-1:0] w_idx_msk;
  logic         w_any_msk;

  // back-to-back capture sees the pointer this accept produces
  assign w_ptr = w_accept ? r_code + W'(1) : r_ptr;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = bus.req[i] && (W'(i) >= w_ptr);
    end
  end

  pri_enc_n #(.N(N), .W(W)) u_msk (
    .i_req (w_mask),
    .o_idx (w_idx_msk),
    .o_any (w_any_msk)
  );

  assign w_win = w_any_msk ? w_idx_msk : w_idx_all;

  always_ff @(posedge clk) begin
    if (reset)         r_ptr <= '0;
    else if (w_accept) r_ptr <= r_code + W'(1);
  end
`else
  assign w_win = w_idx_all;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_capture) w_state_nxt = HOLD;
      HOLD: if (bus.ready) w_state_nxt = w_capture ? HOLD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_code <= w_win;
      if (w_accept)  r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.code    = r_code;
  assign bus.valid   = (r_state == HOLD);
  assign bus.gnt_cnt = r_cnt;
endmodule

// File: tb/tb_enc4_2_rr.sv
// Directed vector bench for enc4_2_rr (either arbitration build).
module tb_enc4_2_rr;
`ifdef ENC_RR_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       en;
    logic       rdy;
    logic       ev;
    logic [1:0] ec;
    logic [7:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  vec_t vq[$];

  enc4_2_rr_if #(.N(4), .CNT_W(8)) bus ();

  enc4_2_rr #(.N(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] req,
                     input logic en, input logic rdy, input logic ev,
                     input logic [1:0] ec, input logic [7:0] ecnt);
    vec_t v;
    v.rst = rst; v.req = req; v.en = en; v.rdy = rdy;
    v.ev = ev; v.ec = ec; v.ecnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [3:0] req,
                       input logic en, input logic rdy);
    reset = rst; bus.req = req; bus.en = en; bus.ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; bus.req = '0; bus.en = 1'b0; bus.ready = 1'b0;
    // rst req en rdy | valid code cnt
    add(1, 4'b1111, 1, 0, 0, 2'd0, 8'd0);
    add(1, 4'b1111, 1, 0, 0, 2'd0, 8'd0);
    add(0, 4'b0100, 1, 0, 1, 2'd2, 8'd0);
    add(0, 4'b0001, 1, 0, 1, 2'd2, 8'd0);
    add(0, 4'b0001, 1, 0, 1, 2'd2, 8'd0);
    add(0, 4'b0001, 1, 0, 1, 2'd2, 8'd0);
    add(0, 4'b0001, 1, 1, 1, 2'd0, 8'd1);
    add(0, 4'b0000, 0, 1, 0, 2'd0, 8'd2);
    add(0, 4'b1000, 0, 0, 0, 2'd0, 8'd2);
    add(0, 4'b1000, 0, 0, 0, 2'd0, 8'd2);
    add(0, 4'b1000, 1, 0, 1, 2'd3, 8'd2);
    add(1, 4'b1000, 1, 0, 0, 2'd0, 8'd0);
    add(0, 4'b1111, 1, 0, 1, 2'd0, 8'd0);
    add(0, 4'b1111, 1, 1, 1, FAIR ? 2'd1 : 2'd0, 8'd1);
    add(0, 4'b1111, 0, 1, 0, FAIR ? 2'd1 : 2'd0, 8'd2);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].req, vq[i].en, vq[i].rdy);
      chk($sformatf("v%0d valid", i), int'(bus.valid), int'(vq[i].ev));
      chk($sformatf("v%0d code", i), int'(bus.code), int'(vq[i].ec));
      chk($sformatf("v%0d cnt", i), int'(bus.gnt_cnt), int'(vq[i].ecnt));
    end

    // saturated requests with ready held: rotation and counter wrap
    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    chk("rr reset valid", int'(bus.valid), 0);
    for (int k = 0; k < 262; k++) begin
      drive(1'b0, 4'b1111, 1'b1, 1'b1);
      chk($sformatf("rr%0d valid", k), int'(bus.valid), 1);
      chk($sformatf("rr%0d code", k), int'(bus.code),
          FAIR ? (k % 4) : 0);
      chk($sformatf("rr%0d cnt", k), int'(bus.gnt_cnt), k % 256);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
